mat_vec_sequencer: RTL and testbench

//  Downstream consumer of the m x n matrix store in the predictor-corrector datapath.
//  On start, sweeps the stored matrix row by row (or column by column when transposed).

---
 rtl/mat_vec_sequencer.sv | 119 +++++++++++
 tb/tb_mat_vec_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mat_vec_sequencer.sv
// Matrix-vector sequencer: sweeps the matrix store row by row, accumulates y = A*x (or A^T*x)
// in fixed point and streams each element out on a valid/ready port. Macro SATURATE_EN selects saturating accumulate.
module mat_vec_sequencer #(
    parameter int FRAC_BITS = 16,
    parameter int DIM_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIM_W-1:0] m_dim,
    input  logic [DIM_W-1:0] n_dim,
    input  logic             transpose,
    output logic             mat_read,
    output logic [DIM_W-1:0] mat_m_addr,
    output logic [DIM_W-1:0] mat_n_addr,
    output logic             mat_tr,
    input  logic [31:0]      mat_data,
    output logic [DIM_W-1:0] vec_addr,
    input  logic [31:0]      vec_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [DIM_W-1:0] y_addr,
    output logic [31:0]      y_data,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start
    // ISSUE | one store/vector read per cycle across the current row
    // DRAIN | last product of the row is accumulated
    // OUT   | result element presented until accepted
    // EMPTY | zero-sized run, one filler cycle before DONE
    // DONE  | one-cycle done pulse
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, OUT, EMPTY, DONE} state_t;

    state_t state, next;

    logic [DIM_W-1:0] r_len, c_len, r, c;
    logic             tr;
    logic             rd_d, first_d;
    logic [31:0]      acc, term, sum;
    logic signed [63:0] prod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:  if (start) next = (m_dim == '0 || n_dim == '0) ? EMPTY : ISSUE;
            ISSUE: if (c == c_len - 1'b1) next = DRAIN;
            DRAIN: next = OUT;
            OUT:   if (y_ready) next = (r == r_len - 1'b1) ? DONE : ISSUE;
            EMPTY: next = DONE;
            DONE:  next = IDLE;
            default: next = IDLE;
        endcase
    end

    assign prod = $signed(mat_data) * $signed(vec_data);
    assign term = 32'(prod >>> FRAC_BITS);

`ifdef SATURATE_EN
    logic [31:0] sum_raw;
    logic        ovf;
    assign sum_raw = acc + term;
    assign ovf     = (acc[31] == term[31]) && (sum_raw[31] != acc[31]);
    assign sum     = ovf ? (acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum_raw;
`else
    assign sum = acc + term;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len   <= '0;
            c_len   <= '0;
            r       <= '0;
            c       <= '0;
            tr      <= 1'b0;
            rd_d    <= 1'b0;
            first_d <= 1'b0;
            acc     <= '0;
        end else begin
            rd_d    <= (state == ISSUE);
            first_d <= (state == ISSUE) && (c == '0);
            if (state == IDLE && start) begin
                r_len <= transpose ? n_dim : m_dim;
                c_len <= transpose ? m_dim : n_dim;
                tr    <= transpose;
                r     <= '0;
                c     <= '0;
            end
            if (state == ISSUE)
                c <= (c == c_len - 1'b1) ? '0 : c + 1'b1;
            if (state == OUT && y_ready)
                r <= (r == r_len - 1'b1) ? '0 : r + 1'b1;
            // Data returns one cycle after its read; the row's first term overwrites acc.
            if (rd_d)
                acc <= first_d ? term : sum;
            else if (state == OUT && y_ready)
                acc <= '0;
        end
    end

    assign mat_read   = (state == ISSUE);
    assign mat_m_addr = r;
    assign mat_n_addr = c;
    assign vec_addr   = c;
    assign mat_tr     = tr;
    assign y_valid    = (state == OUT);
    assign y_addr     = y_valid ? r : '0;
    assign y_data     = y_valid ? acc : '0;
    assign busy       = (state == ISSUE) || (state == DRAIN) || (state == OUT) || (state == EMPTY);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_mat_vec_sequencer.sv
// Bench for mat_vec_sequencer: table of matrix/vector cases with a result scoreboard,
// plus hand sequences for backpressure, zero dimensions and mid-run reset.
module tb_mat_vec_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  m_dim = '0, n_dim = '0;
    logic        transpose = 1'b0;
    logic        y_ready = 1'b1;
    logic [31:0] mat_data = '0, vec_data = '0;
    logic        mat_read, mat_tr, y_valid, busy, done;
    logic [7:0]  mat_m_addr, mat_n_addr, vec_addr, y_addr;
    logic [31:0] y_data;

    mat_vec_sequencer #(.FRAC_BITS(16), .DIM_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .m_dim(m_dim), .n_dim(n_dim),
        .transpose(transpose), .mat_read(mat_read), .mat_m_addr(mat_m_addr),
        .mat_n_addr(mat_n_addr), .mat_tr(mat_tr), .mat_data(mat_data),
        .vec_addr(vec_addr), .vec_data(vec_data), .y_valid(y_valid), .y_ready(y_ready),
        .y_addr(y_addr), .y_data(y_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Matrix store and x-vector model, row-major with stride 3.
    logic [31:0] amem [0:8];
    logic [31:0] xmem [0:2];
    int          cur_m = 0, cur_n = 0;
    logic        cur_tr = 1'b0;
    int          bad_addr = 0;

    always @(posedge clk) begin
        if (mat_read) begin
            if (cur_tr ? (int'(mat_m_addr) >= cur_n || int'(mat_n_addr) >= cur_m)
                       : (int'(mat_m_addr) >= cur_m || int'(mat_n_addr) >= cur_n))
                bad_addr <= bad_addr + 1;
            if (mat_m_addr < 3 && mat_n_addr < 3)
                mat_data <= cur_tr ? amem[int'(mat_n_addr)*3 + int'(mat_m_addr)]
                                   : amem[int'(mat_m_addr)*3 + int'(mat_n_addr)];
            if (vec_addr < 3) vec_data <= xmem[vec_addr];
        end
    end

    typedef struct {
        logic [7:0]       m, n;
        logic             tr;
        logic [8:0][31:0] a;
        logic [2:0][31:0] x;
        logic [2:0][31:0] y;
        int               cyc;
    } vec_t;

    typedef struct { logic [7:0] a; logic [31:0] d; } exp_t;

    vec_t vt [5];
    exp_t sbq [$];
    int   total = 0, passed = 0;
    int   rd_cnt = 0, yv_cnt = 0, done_cnt = 0, ovl_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Observe at the falling edge, then advance to just after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (mat_read) rd_cnt++;
        if (y_valid) yv_cnt++;
        if (done) done_cnt++;
        if (y_valid && mat_read) ovl_cnt++;
        if (y_valid && y_ready) begin
            if (sbq.size() == 0) check("sb_unexpected", {24'h0, y_addr}, 32'hFFFF_FFFF);
            else begin
                e = sbq.pop_front();
                check("y_addr", {24'h0, y_addr}, {24'h0, e.a});
                check("y_data", y_data, e.d);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int k);
        for (int i = 0; i < 9; i++) amem[i] = vt[k].a[i];
        for (int i = 0; i < 3; i++) xmem[i] = vt[k].x[i];
        cur_m = int'(vt[k].m); cur_n = int'(vt[k].n); cur_tr = vt[k].tr;
    endtask

    task automatic pulse_start(input logic [7:0] m, input logic [7:0] n, input logic tr);
        m_dim = m; n_dim = n; transpose = tr; start = 1'b1;
        tick();
        start = 1'b0;
        m_dim = 8'd0; n_dim = 8'd1; transpose = ~tr;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 600) begin tick(); cyc++; end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input int k);
        int cyc, d0, rows;
        load(k);
        rows = vt[k].tr ? int'(vt[k].n) : int'(vt[k].m);
        for (int i = 0; i < rows; i++) sbq.push_back('{a: 8'(i), d: vt[k].y[i]});
        d0 = done_cnt;
        pulse_start(vt[k].m, vt[k].n, vt[k].tr);
        check("busy_run", {31'd0, busy}, 32'd1);
        check("mat_tr", {31'd0, mat_tr}, {31'd0, vt[k].tr});
        wait_done(cyc);
        check("start_to_done", cyc, vt[k].cyc);
        tick(); tick();
        check("done_count", done_cnt - d0, 32'd1);
        check("sb_empty", sbq.size(), 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cyc, r0, y0, d0, errs, n;
        for (int k = 0; k < 5; k++) begin
            vt[k].a = '0; vt[k].x = '0; vt[k].y = '0;
        end
        // identity 3x3, x=[1,2,3]
        vt[0].m = 3; vt[0].n = 3; vt[0].tr = 0; vt[0].cyc = 16;
        vt[0].a[0] = 32'h10000; vt[0].a[4] = 32'h10000; vt[0].a[8] = 32'h10000;
        vt[0].x[0] = 32'h10000; vt[0].x[1] = 32'h20000; vt[0].x[2] = 32'h30000;
        vt[0].y[0] = 32'h10000; vt[0].y[1] = 32'h20000; vt[0].y[2] = 32'h30000;
        // 2x3 transposed, x=[1,1]
        vt[1].m = 2; vt[1].n = 3; vt[1].tr = 1; vt[1].cyc = 13;
        vt[1].a[0] = 32'h10000; vt[1].a[1] = 32'h20000; vt[1].a[2] = 32'h30000;
        vt[1].a[3] = 32'h40000; vt[1].a[4] = 32'h50000; vt[1].a[5] = 32'h60000;
        vt[1].x[0] = 32'h10000; vt[1].x[1] = 32'h10000;
        vt[1].y[0] = 32'h50000; vt[1].y[1] = 32'h70000; vt[1].y[2] = 32'h90000;
        // accumulate overflow
        vt[2].m = 1; vt[2].n = 2; vt[2].tr = 0; vt[2].cyc = 5;
        vt[2].a[0] = 32'h7FFF0000; vt[2].a[1] = 32'h7FFF0000;
        vt[2].x[0] = 32'h10000; vt[2].x[1] = 32'h10000;
`ifdef SATURATE_EN
        vt[2].y[0] = 32'h7FFFFFFF;
`else
        vt[2].y[0] = 32'hFFFE0000;
`endif
        // signed 2x2: [[-1.5,2],[0.5,-3]] * [2,-1] = [-5,4]
        vt[3].m = 2; vt[3].n = 2; vt[3].tr = 0; vt[3].cyc = 9;
        vt[3].a[0] = 32'hFFFE8000; vt[3].a[1] = 32'h20000;
        vt[3].a[3] = 32'h08000;    vt[3].a[4] = 32'hFFFD0000;
        vt[3].x[0] = 32'h20000; vt[3].x[1] = 32'hFFFF0000;
        vt[3].y[0] = 32'hFFFB0000; vt[3].y[1] = 32'h40000;
        // truncation toward -inf: -1ulp * 0.5 -> -1ulp
        vt[4].m = 1; vt[4].n = 1; vt[4].tr = 0; vt[4].cyc = 4;
        vt[4].a[0] = 32'hFFFFFFFF; vt[4].x[0] = 32'h08000;
        vt[4].y[0] = 32'hFFFFFFFF;

        tick(); tick();
        check("rst_ctl", {27'd0, mat_read, mat_tr, y_valid, busy, done}, 32'd0);
        check("rst_addr", {mat_m_addr, mat_n_addr, vec_addr, y_addr}, 32'd0);
        check("rst_ydata", y_data, 32'd0);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 5; k++) run_vec(k);

        // backpressure on row 0
        load(0);
        for (int i = 0; i < 3; i++) sbq.push_back('{a: 8'(i), d: vt[0].y[i]});
        y_ready = 1'b0;
        pulse_start(3, 3, 0);
        n = 0;
        while (!y_valid && n < 50) begin tick(); n++; end
        check("bp_valid", {31'd0, y_valid}, 32'd1);
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!y_valid || y_data !== 32'h10000 || y_addr !== 8'd0 || mat_read) errs++;
        end
        check("bp_hold", errs, 32'd0);
        y_ready = 1'b1;
        wait_done(cyc);
        tick(); tick();
        check("bp_sb_empty", sbq.size(), 32'd0);

        // zero dimension
        r0 = rd_cnt; y0 = yv_cnt; d0 = done_cnt;
        pulse_start(0, 3, 0);
        wait_done(cyc);
        check("zero_cycles", cyc, 32'd2);
        tick(); tick();
        check("zero_reads", rd_cnt - r0, 32'd0);
        check("zero_yvalid", yv_cnt - y0, 32'd0);
        check("zero_done", done_cnt - d0, 32'd1);

        // reset during row 1 issue
        load(0);
        sbq.push_back('{a: 8'd0, d: 32'h10000});
        pulse_start(3, 3, 0);
        n = 0;
        while (!(mat_read && mat_m_addr == 8'd1) && n < 50) begin tick(); n++; end
        check("reach_row1", {31'd0, mat_read}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_ctl", {27'd0, mat_read, mat_tr, y_valid, busy, done}, 32'd0);
        check("mid_rst_addr", {mat_m_addr, mat_n_addr, vec_addr, y_addr}, 32'd0);
        check("mid_rst_ydata", y_data, 32'd0);
        tick(); tick();
        reset = 1'b0;
        sbq.delete();
        tick();
        run_vec(0);

        check("addr_range", bad_addr, 32'd0);
        check("read_in_out", ovl_cnt, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
